// File: rtl/dmem_wait_responder.sv
// Word-organised little-endian data memory behind a req/ready handshake with LATENCY wait states.
// Optional DMEM_MISALIGN_TRAP_EN: faulting accesses raise err and misaligned ones are suppressed.
module dmem_wait_responder #(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [2:0]  mode,
    input  logic [31:0] a,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    output logic        ready,
    output logic        busy,
    output logic        err
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [2:0] M_B  = 3'b000;
    localparam logic [2:0] M_H  = 3'b001;
    localparam logic [2:0] M_W  = 3'b010;
    localparam logic [2:0] M_BU = 3'b100;
    localparam logic [2:0] M_HU = 3'b101;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic        we_q;
    logic [2:0]  mode_q;
    logic [31:0] a_q;
    logic [31:0] wd_q;

    logic [31:0] mem [DEPTH];

    logic          in_range;
    logic          legal;
    logic          misal;
    logic          fault;
    logic          err_cond;
    logic [AW-1:0] idx;
    logic [31:0]   word;
    logic [7:0]    byte_sel;
    logic [15:0]   half_sel;
    logic [31:0]   ld_data;
    logic [31:0]   st_data;
    logic [3:0]    st_be;
    logic          commit;

    assign in_range = (a_q[31:2] < 30'(DEPTH));
    assign idx      = a_q[AW+1:2];
    assign legal    = (mode_q == M_B) || (mode_q == M_H) || (mode_q == M_W) ||
                      (mode_q == M_BU) || (mode_q == M_HU);
    assign misal    = ((mode_q[1:0] == 2'b01) && a_q[0]) ||
                      ((mode_q == M_W) && (a_q[1:0] != 2'b00));

`ifdef DMEM_MISALIGN_TRAP_EN
    assign fault    = !in_range || !legal || misal;
    assign err_cond = fault;
`else
    // Misaligned accesses align down naturally through the lane selects below.
    assign fault    = !in_range || !legal;
    assign err_cond = 1'b0;
`endif

    assign word     = in_range ? mem[idx] : 32'h0;
    assign byte_sel = word[{a_q[1:0], 3'b000} +: 8];
    assign half_sel = a_q[1] ? word[31:16] : word[15:0];

    always_comb begin
        ld_data = 32'h0;
        if (!fault) begin
            case (mode_q)
                M_B:     ld_data = {{24{byte_sel[7]}}, byte_sel};
                M_BU:    ld_data = {24'h0, byte_sel};
                M_H:     ld_data = {{16{half_sel[15]}}, half_sel};
                M_HU:    ld_data = {16'h0, half_sel};
                M_W:     ld_data = word;
                default: ld_data = 32'h0;
            endcase
        end
    end

    // Store data is replicated across lanes so the byte enables alone pick the target.
    always_comb begin
        st_data = wd_q;
        st_be   = 4'b0000;
        case (mode_q)
            M_B, M_BU: begin
                st_data = {4{wd_q[7:0]}};
                st_be   = 4'b0001 << a_q[1:0];
            end
            M_H, M_HU: begin
                st_data = {2{wd_q[15:0]}};
                st_be   = a_q[1] ? 4'b1100 : 4'b0011;
            end
            M_W: begin
                st_data = wd_q;
                st_be   = 4'b1111;
            end
            default: st_be = 4'b0000;
        endcase
    end

    assign commit = (state == WAIT) && (cnt == 4'd0);

    always_ff @(posedge clk) begin
        if (commit && we_q && !fault) begin
            for (int i = 0; i < 4; i++) begin
                if (st_be[i]) mem[idx][8*i +: 8] <= st_data[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            cnt    <= 4'd0;
            rd     <= 32'h0;
            ready  <= 1'b0;
            busy   <= 1'b0;
            err    <= 1'b0;
            we_q   <= 1'b0;
            mode_q <= 3'b000;
            a_q    <= 32'h0;
            wd_q   <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    ready <= 1'b0;
                    err   <= 1'b0;
                    if (req) begin
                        we_q   <= we;
                        mode_q <= mode;
                        a_q    <= a;
                        wd_q   <= wd;
                        cnt    <= 4'(LATENCY - 1);
                        busy   <= 1'b1;
                        state  <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt == 4'd0) begin
                        ready <= 1'b1;
                        err   <= err_cond;
                        if (!we_q) rd <= ld_data;
                        state <= RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    ready <= 1'b0;
                    err   <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    ready <= 1'b0;
                    err   <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_wait_responder.sv
// Randomised bench for dmem_wait_responder: a word-array memory model predicts every response and
// a per-cycle process checks ready/busy/rd/err; directed literal checks pin the model.
module tb_dmem_wait_responder;
    localparam int L = 2;
    localparam int D = 256;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [2:0]  mode = 3'b000;
    logic [31:0] a = 32'h0;
    logic [31:0] wd = 32'h0;
    logic [31:0] rd;
    logic        ready;
    logic        busy;
    logic        err;

    dmem_wait_responder #(.DEPTH(D), .LATENCY(L)) dut (
        .clk(clk), .reset(reset), .req(req), .we(we), .mode(mode),
        .a(a), .wd(wd), .rd(rd), .ready(ready), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    int          vectors = 0;
    int          errors  = 0;
    int          cyc     = 0;
    int          t_req   = -100;
    bit          pending = 1'b0;
    bit          p_load  = 1'b0;
    logic [31:0] p_rd    = 32'h0;
    bit          p_err   = 1'b0;
    logic [31:0] exp_rd  = 32'h0;
    bit          seen_err = 1'b0;
    logic [31:0] mem_m [D];

`ifdef DMEM_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Every cycle: outputs follow from the time of the last capture and the model's prediction.
    always @(negedge clk) begin
        int  d;
        bit  in_resp;
        bit  exp_busy;
        if (!reset) begin
            exp_rd = 32'h0;
            check("rst_ready", {31'h0, ready}, 32'h0);
            check("rst_busy",  {31'h0, busy},  32'h0);
            check("rst_rd",    rd,             32'h0);
            check("rst_err",   {31'h0, err},   32'h0);
        end else begin
            d        = cyc - t_req;
            in_resp  = pending && (d == L);
            exp_busy = pending && (d >= 0) && (d <= L);
            if (in_resp && p_load) exp_rd = p_rd;
            check("ready", {31'h0, ready}, {31'h0, in_resp});
            check("busy",  {31'h0, busy},  {31'h0, exp_busy});
            check("rd",    rd,             exp_rd);
            check("err",   {31'h0, err},   {31'h0, in_resp && p_err});
            if (ready) seen_err = err;
        end
    end

    // Behavioural model: decides fault, applies stores to mem_m and predicts load data.
    task automatic model_apply(input bit w, input logic [2:0] m, input logic [31:0] addr,
                               input logic [31:0] data);
        int unsigned widx  = addr >> 2;
        int unsigned boff  = addr % 4;
        int unsigned hoff  = (addr >> 1) % 2;
        bit          illeg = (m == 3) || (m == 6) || (m == 7);
        bit          oor   = widx >= D;
        bit          mis   = ((m == 1 || m == 5) && (addr % 2 != 0)) || (m == 2 && boff != 0);
        bit          fault = illeg || oor || (TRAP && mis);
        logic [31:0] w32;
        logic [31:0] v;
        p_load = !w;
        p_err  = TRAP && fault;
        p_rd   = 32'h0;
        if (fault) return;
        w32 = mem_m[widx];
        if (w) begin
            if (m == 0 || m == 4)
                w32 = (w32 & ~(32'hFF << (8*boff))) | ((data & 32'hFF) << (8*boff));
            else if (m == 1 || m == 5)
                w32 = (w32 & ~(32'hFFFF << (16*hoff))) | ((data & 32'hFFFF) << (16*hoff));
            else
                w32 = data;
            mem_m[widx] = w32;
        end else begin
            if (m == 0 || m == 4) begin
                v = (w32 >> (8*boff)) & 32'hFF;
                if (m == 0 && v >= 128) v = v | 32'hFFFFFF00;
            end else if (m == 1 || m == 5) begin
                v = (w32 >> (16*hoff)) & 32'hFFFF;
                if (m == 1 && v >= 32768) v = v | 32'hFFFF0000;
            end else begin
                v = w32;
            end
            p_rd = v;
        end
    endtask

    task automatic access(input bit w, input logic [2:0] m, input logic [31:0] addr,
                          input logic [31:0] data, input bit hold);
        @(negedge clk);
        req = 1'b1; we = w; mode = m; a = addr; wd = data;
        @(posedge clk); #1;
        t_req = cyc;
        model_apply(w, m, addr, data);
        pending = 1'b1;
        if (!hold) begin
            req = 1'b0; we = $urandom; mode = 3'($urandom); a = $urandom; wd = $urandom;
        end
        repeat (L) @(posedge clk);
        #1 req = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        // Reset, then idle with no request for 20 cycles.
        repeat (3) @(posedge clk);
        #2 reset = 1'b1;
        repeat (20) @(posedge clk);
        #1;

        for (int i = 0; i < D; i++) begin
            mem_m[i] = 32'h0;
            access(1'b1, 3'b010, 32'(i * 4), 32'h0, 1'b0);
        end

        access(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 1'b1);
        access(1'b0, 3'b010, 32'h10, 32'h0, 1'b1);
        check("lw_10", rd, 32'hDEADBEEF);

        access(1'b1, 3'b000, 32'h21, 32'h80, 1'b0);
        access(1'b0, 3'b000, 32'h21, 32'h0, 1'b1);
        check("lb_21", rd, 32'hFFFFFF80);
        access(1'b0, 3'b100, 32'h21, 32'h0, 1'b0);
        check("lbu_21", rd, 32'h00000080);
        access(1'b0, 3'b010, 32'h20, 32'h0, 1'b1);
        check("lw_20", rd, 32'h00008000);

        access(1'b1, 3'b001, 32'h32, 32'hFFFF8001, 1'b1);
        access(1'b0, 3'b001, 32'h32, 32'h0, 1'b0);
        check("lh_32", rd, 32'hFFFF8001);
        access(1'b0, 3'b101, 32'h32, 32'h0, 1'b1);
        check("lhu_32", rd, 32'h00008001);
        access(1'b0, 3'b010, 32'h30, 32'h0, 1'b0);
        check("lw_30", rd, 32'h80010000);

        // Reset during WAIT discards the store; the model is not updated for it.
        access(1'b1, 3'b010, 32'h40, 32'hCAFEF00D, 1'b0);
        @(negedge clk);
        req = 1'b1; we = 1'b1; mode = 3'b010; a = 32'h40; wd = 32'h12345678;
        @(posedge clk); #1;
        req = 1'b0;
        pending = 1'b0;
        #2 reset = 1'b0;
        repeat (2) @(posedge clk);
        #2 reset = 1'b1;
        @(posedge clk); #1;
        access(1'b0, 3'b010, 32'h40, 32'h0, 1'b1);
        check("lw_40_after_rst", rd, 32'hCAFEF00D);

        access(1'b0, 3'b010, 32'h402, 32'h0, 1'b1);
        check("lw_402", rd, 32'h0);
        check("err_402", {31'h0, seen_err}, {31'h0, TRAP});
        access(1'b1, 3'b010, 32'h06, 32'hA5A5A5A5, 1'b0);
        access(1'b0, 3'b010, 32'h04, 32'h0, 1'b1);
        check("lw_04", rd, TRAP ? 32'h0 : 32'hA5A5A5A5);

        for (int n = 0; n < 400; n++) begin
            bit          rw;
            logic [2:0]  rm;
            int unsigned widx;
            logic [31:0] addr;
            rw   = 1'($urandom);
            rm   = 3'($urandom);
            widx = ($urandom % 10 == 0) ? D + $urandom % 64 : $urandom % 16;
            addr = 32'((widx << 2) | ($urandom % 4));
            access(rw, rm, addr, $urandom, 1'($urandom));
            repeat ($urandom % 3) @(posedge clk);
            #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
